// File: rtl/conv_engine.sv
// rtl/conv_engine.sv - KSIZE x KSIZE valid-mode, stride-1, multi-channel fixed-point convolution engine
// Optional feature: define CONV_ENGINE_RELU_EN to clamp negative results to zero before writing.
// Ports: clk, reset (async active-low); start/busy/done operation handshake;
//        img_base/wgt_base/dst_base, img_rows/img_cols operation configuration;
//        img_address/img_readdata, wgt_address/wgt_readdata 1-cycle-latency SRAM reads;
//        dest_address/dest_writedata/dest_write result writes.
module conv_engine #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ADDR_W    = 12,
    parameter int DIM_W     = 6,
    parameter int KSIZE     = 3,
    parameter int NUM_CH    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  img_rows,
    input  logic [DIM_W-1:0]  img_cols,
    output logic [ADDR_W-1:0] img_address,
    input  logic [DATA_W-1:0] img_readdata,
    output logic [ADDR_W-1:0] wgt_address,
    input  logic [DATA_W-1:0] wgt_readdata,
    output logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_writedata,
    output logic              dest_write
);
    localparam int KK    = KSIZE * KSIZE;
    localparam int NW    = NUM_CH * KK;
    localparam int ACC_W = 2 * DATA_W + 8;
    localparam int LD_W  = $clog2(NW + 1);
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int TAP_W = $clog2(KK + 1);
    localparam int KC_W  = $clog2(KSIZE + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIM_W-1:0] K_DIM = DIM_W'(KSIZE);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_W, MAC, STORE, DONE} state_t;

    state_t              state_q, state_d;
    logic [LD_W-1:0]     ld_cnt_q, ld_cnt_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [KC_W-1:0]     kc_q, kc_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DIM_W-1:0]    out_r_q, out_r_d, out_c_q, out_c_d, oh_q, oh_d, ow_q, ow_d;
    logic [ADDR_W-1:0]   wgt_base_q, wgt_base_d, dst_base_q, dst_base_d;
    logic [ADDR_W-1:0]   row_step_q, row_step_d, plane_q, plane_d;
    logic [ADDR_W-1:0]   ch_off_q, ch_off_d, pix_q, pix_d, win_q, win_d, ptr_q, ptr_d;
    logic signed [ACC_W-1:0] acc_q [NUM_CH];
    logic signed [ACC_W-1:0] acc_d [NUM_CH];

    // Weight store has no reset: contents are meaningless until the next LOAD_W.
    logic signed [DATA_W-1:0]   wgt_q [NW];
    logic                       wgt_we;
    logic [IDX_W-1:0]           wgt_widx;
    logic signed [2*DATA_W-1:0] prod [NUM_CH];
    logic [TAP_W-1:0]           tap_m1;
    logic [DIM_W-1:0]           oh_in, ow_in;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          sat_res;

    // Data arriving this cycle belongs to the tap addressed last cycle.
    always_comb begin
        tap_m1 = (tap_q == '0) ? '0 : tap_q - TAP_W'(1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            prod[ch] = $signed(img_readdata) * wgt_q[IDX_W'(ch * KK) + IDX_W'(tap_m1)];
        end
    end

    always_comb begin
        shifted = acc_q[ch_q] >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sat_res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_res = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_res = shifted[DATA_W-1:0];
        end
`ifdef CONV_ENGINE_RELU_EN
        if (sat_res[DATA_W-1]) begin
            sat_res = '0;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        ld_cnt_d       = ld_cnt_q;
        tap_d          = tap_q;
        kc_d           = kc_q;
        ch_d           = ch_q;
        out_r_d        = out_r_q;
        out_c_d        = out_c_q;
        oh_d           = oh_q;
        ow_d           = ow_q;
        wgt_base_d     = wgt_base_q;
        dst_base_d     = dst_base_q;
        row_step_d     = row_step_q;
        plane_d        = plane_q;
        ch_off_d       = ch_off_q;
        pix_d          = pix_q;
        win_d          = win_q;
        ptr_d          = ptr_q;
        acc_d          = acc_q;
        wgt_we         = 1'b0;
        wgt_widx       = IDX_W'(ld_cnt_q - LD_W'(1));
        oh_in          = img_rows - K_DIM + DIM_W'(1);
        ow_in          = img_cols - K_DIM + DIM_W'(1);
        img_address    = '0;
        wgt_address    = '0;
        dest_address   = '0;
        dest_writedata = '0;
        dest_write     = 1'b0;
        done           = 1'b0;
        busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    oh_d       = oh_in;
                    ow_d       = ow_in;
                    plane_d    = ADDR_W'((2*DIM_W)'(oh_in) * (2*DIM_W)'(ow_in));
                    // Jump from the last tap of a window row to the first tap of the next row.
                    row_step_d = ADDR_W'(img_cols) - ADDR_W'(KSIZE) + ADDR_W'(1);
                    wgt_base_d = wgt_base;
                    dst_base_d = dst_base;
                    win_d      = img_base;
                    ptr_d      = img_base;
                    out_r_d    = '0;
                    out_c_d    = '0;
                    pix_d      = '0;
                    ld_cnt_d   = '0;
                    tap_d      = '0;
                    kc_d       = '0;
                    ch_d       = '0;
                    ch_off_d   = '0;
                    if (img_rows < K_DIM || img_cols < K_DIM) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (ld_cnt_q < LD_W'(NW)) begin
                    wgt_address = wgt_base_q + ADDR_W'(ld_cnt_q);
                end
                wgt_we = (ld_cnt_q != '0);
                if (ld_cnt_q == LD_W'(NW)) begin
                    state_d = MAC;
                end else begin
                    ld_cnt_d = ld_cnt_q + LD_W'(1);
                end
            end
            MAC: begin
                // Tap 0 has no returning data yet, so it doubles as the window clear.
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (tap_q == '0) begin
                        acc_d[ch] = '0;
                    end else begin
                        acc_d[ch] = acc_q[ch] + {{8{prod[ch][2*DATA_W-1]}}, prod[ch]};
                    end
                end
                if (tap_q < TAP_W'(KK)) begin
                    img_address = ptr_q;
                    tap_d       = tap_q + TAP_W'(1);
                    if (kc_q == KC_W'(KSIZE - 1)) begin
                        kc_d  = '0;
                        ptr_d = ptr_q + row_step_q;
                    end else begin
                        kc_d  = kc_q + KC_W'(1);
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d  = STORE;
                    ch_d     = '0;
                    ch_off_d = '0;
                end
            end
            STORE: begin
                dest_write     = 1'b1;
                dest_address   = dst_base_q + ch_off_q + pix_q;
                dest_writedata = sat_res;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    tap_d = '0;
                    kc_d  = '0;
                    if (out_r_q == oh_q - DIM_W'(1) && out_c_q == ow_q - DIM_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = MAC;
                        pix_d   = pix_q + ADDR_W'(1);
                        if (out_c_q == ow_q - DIM_W'(1)) begin
                            // Window origin moves from (r, OW-1) to (r+1, 0): a step of KSIZE.
                            out_c_d = '0;
                            out_r_d = out_r_q + DIM_W'(1);
                            win_d   = win_q + ADDR_W'(KSIZE);
                            ptr_d   = win_q + ADDR_W'(KSIZE);
                        end else begin
                            out_c_d = out_c_q + DIM_W'(1);
                            win_d   = win_q + ADDR_W'(1);
                            ptr_d   = win_q + ADDR_W'(1);
                        end
                    end
                end else begin
                    ch_d     = ch_q + CH_W'(1);
                    ch_off_d = ch_off_q + plane_q;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            tap_q      <= '0;
            kc_q       <= '0;
            ch_q       <= '0;
            out_r_q    <= '0;
            out_c_q    <= '0;
            oh_q       <= '0;
            ow_q       <= '0;
            wgt_base_q <= '0;
            dst_base_q <= '0;
            row_step_q <= '0;
            plane_q    <= '0;
            ch_off_q   <= '0;
            pix_q      <= '0;
            win_q      <= '0;
            ptr_q      <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_q[ch] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            tap_q      <= tap_d;
            kc_q       <= kc_d;
            ch_q       <= ch_d;
            out_r_q    <= out_r_d;
            out_c_q    <= out_c_d;
            oh_q       <= oh_d;
            ow_q       <= ow_d;
            wgt_base_q <= wgt_base_d;
            dst_base_q <= dst_base_d;
            row_step_q <= row_step_d;
            plane_q    <= plane_d;
            ch_off_q   <= ch_off_d;
            pix_q      <= pix_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_q[ch] <= acc_d[ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wgt_we) begin
            wgt_q[wgt_widx] <= wgt_readdata;
        end
    end
endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed fixed-point pixel/weight width.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of DATA_W values.
REQ-003 SHALL have parameter ADDR_W, default 12, SRAM address width.
REQ-004 SHALL have parameter DIM_W, default 6, image dimension width.
REQ-005 SHALL have parameter KSIZE, default 3, square kernel edge, legal 1..7.
REQ-006 SHALL have parameter NUM_CH, default 3, output channels (kernels), legal 1..8.
REQ-007 SHALL have ports: clk in 1 clock; reset in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: start in 1 start pulse; busy out 1 operation in progress; done out 1 one-cycle completion pulse.
REQ-009 SHALL have ports: img_base, wgt_base, dst_base in ADDR_W each, region base addresses; img_rows, img_cols in DIM_W each, image size.
REQ-010 SHALL have ports: img_address out ADDR_W; img_readdata in DATA_W; wgt_address out ADDR_W; wgt_readdata in DATA_W.
REQ-011 SHALL have ports: dest_address out ADDR_W; dest_writedata out DATA_W; dest_write out 1.

Function
REQ-012 SHALL treat both read SRAMs as 1-cycle latency: data for address driven in cycle n is valid in cycle n+1.
REQ-013 SHALL sample all base/size inputs when start is accepted in IDLE; start while busy SHALL be ignored.
REQ-014 SHALL implement states IDLE, LOAD_W, MAC, STORE, DONE; IDLE->LOAD_W on start; LOAD_W->MAC after NUM_CH*KSIZE*KSIZE weights captured; MAC->STORE after KSIZE*KSIZE products accumulated; STORE->MAC for next pixel or ->DONE after last; DONE->IDLE next cycle.
REQ-015 SHALL load weights in order channel-major, then row, then column, from consecutive addresses starting at wgt_base.
REQ-016 SHALL compute valid (no padding), stride-1 convolution: OH=img_rows-KSIZE+1, OW=img_cols-KSIZE+1, pixels produced row-major.
REQ-017 SHALL address image pixel (r,c) at img_base+r*img_cols+c, one read per cycle in MAC, no idle cycles between pixel windows except the STORE cycles.
REQ-018 SHALL accumulate all NUM_CH channels in parallel in signed accumulators of 2*DATA_W+8 bits, cleared at the start of each window.
REQ-019 SHALL form result = accumulator arithmetically shifted right by FRAC_BITS, saturated to signed DATA_W range.
REQ-020 SHALL write channel ch of output pixel p to dst_base+ch*OH*OW+p, one channel per cycle in STORE, ch ascending, dest_write high exactly NUM_CH cycles per pixel.
REQ-021 SHALL assert busy from the cycle after start accepted until the DONE cycle inclusive; done high for exactly one cycle in DONE.
REQ-022 SHALL, if img_rows<KSIZE or img_cols<KSIZE, go IDLE->DONE with no SRAM writes.
REQ-023 SHALL wrap address arithmetic modulo 2^ADDR_W without error indication.
REQ-024 SHALL complete in 1+NUM_CH*KSIZE*KSIZE+1 + OH*OW*(KSIZE*KSIZE+1+NUM_CH) + 1 cycles from start to done.

Reset
REQ-025 SHALL, on reset low at any time, immediately force state IDLE, busy 0, done 0, dest_write 0, all addresses 0, dest_writedata 0, accumulators 0, aborting any operation.
REQ-026 SHALL resume normal operation on the first clk edge after reset deasserts; stored weights SHALL be undefined until reloaded.

Configuration
REQ-027 SHALL, with macro CONV_ENGINE_RELU_EN defined, clamp negative saturated results to 0 before writing.
REQ-028 SHALL, without CONV_ENGINE_RELU_EN, write signed saturated results unmodified.

Verification
REQ-029 5x5 image of value 0x0100, 3 kernels all 0x0100 (1.0), defaults -> 27 writes; every value 0x0900; channel bases at dst_base, +9, +18.
REQ-030 Kernel 1 center-only 0x0100, image ramp 0..24 (integer<<8) -> channel 0 outputs equal the 3x3 interior pixels in row-major order.
REQ-031 Image and weights all 0x7FFF -> every output 0x7FFF (positive saturation); weights 0x8000 -> 0x8000 without RELU, 0x0000 with CONV_ENGINE_RELU_EN.
REQ-032 img_rows=2, KSIZE=3 -> done one cycle after start accepted, busy pulse only, zero writes.
REQ-033 Reset low mid-MAC on pixel 4 -> outputs at reset values same cycle; new start after release completes full correct run.
REQ-034 start asserted every cycle during a run -> exactly one done, write count NUM_CH*OH*OW, cycle count per REQ-024.
